isqrt_recon: RTL and testbench
==============================

# isqrt_recon

Sequential radicand reconstructor: the inverse of the integer square-root unit. Given a root and remainder, it rebuilds the 16-bit value root² + rem by accumulating successive odd numbers, one per clock. It uses the same oper/done request handshake as the square-root unit. It sits beside that unit in the ALU so results can be round-trip checked or re-expanded.

## Interface
- No parameters; widths fixed: root 8 bits, rem 9 bits, value 16 bits.
- clk  input  1  clock; all state and datapath registers update on rising edge.
- reset  input  1  asynchronous, active-high; clears state and all output registers.
- oper  input  1  operation request level; sampled in IDLE.
- root  input  8  root operand; latched in LOAD.
- rem  input  9  remainder operand; latched in LOAD.
- value  output  16  reconstructed radicand, low 16 bits of root² + rem.
- done  output  1  high while the state is DONE.
- busy  output  1  high in LOAD and ACC.
- ovf  output  1  root² + rem ≥ 65536; valid with done.
- bad_rem  output  1  rem > 2·root, meaning the pair is non-canonical; valid with done.

## Operation
- Registers:
  - root_r[7:0], rem_r[8:0].
  - acc[16:0] is the accumulator.
  - odd[8:0] is the next odd addend, maximum 511.
  - cnt[7:0] counts additions.
- IDLE:
  - oper=1 → LOAD.
  - Otherwise stay in IDLE; value, ovf and bad_rem hold their last values.
- LOAD (one cycle):
  - root_r←root, rem_r←rem.
  - acc←{8'b0,rem}, odd←1, cnt←0.
  - value, ovf and bad_rem are cleared to 0.
  - → ACC.
- ACC:
  - If cnt==root_r → DONE, with no add on that edge.
  - Otherwise acc←acc+odd, odd←odd+2, cnt←cnt+1, and stay in ACC.
- On the ACC→DONE edge:
  - value←acc[15:0], ovf←acc[16].
  - bad_rem←(rem_r > {root_r,1'b0}), using a 9-bit compare.
- DONE:
  - Stay while oper=1; → IDLE when oper=0.
  - A new request therefore requires oper to drop first.
- oper, root and rem changes while busy or in DONE are ignored; operands are captured only in LOAD.
- Arithmetic:
  - The sum of the first n odd numbers is n², so the final acc = root² + rem.
  - The 17-bit acc cannot wrap: the maximum is 65025 + 511 = 65536.
  - Overflow is only possible when bad_rem=1.
- Reset mid-operation: the state returns to IDLE immediately (asynchronously). value, done, busy, ovf, bad_rem, acc, odd and cnt are all 0. No partial result is retained.

## Timing
- Reset values:
  - value=0, done=0, busy=0, ovf=0, bad_rem=0.
  - State is IDLE.
- Edge E0 (oper=1 in IDLE) → LOAD.
- E1 → ACC.
- E2 … E(root+1) perform the root additions.
- E(root+2) → DONE.
- done rises after edge E(root+2), i.e. root+3 rising edges counting E0.
  - root=0: 3 edges.
  - root=255: 258 edges.
- busy is high from after E0 until after E(root+2). busy and done are never high together.
- done and value are stable for the whole DONE residency.
- done falls on the first rising edge sampling oper=0 in DONE.
- The earliest next request is sampled on the following edge in IDLE.
- oper held high continuously never starts a second operation.

## Test plan
- root=31, rem=39, oper pulse held until done:
  - value=1000, ovf=0, bad_rem=0.
  - done rises 34 edges after the sampling edge.
- root=10, rem=0 → value=100 after 13 edges; then root=40, rem=9 → value=1609. busy and done are never high together.
- root=0, rem=1 → value=1, done after 3 edges, bad_rem=1 (1 > 0).
- root=255, rem=510 → value=65535, ovf=0, bad_rem=0. Then root=255, rem=511 → value=0, ovf=1, bad_rem=1.
- Reset:
  - Start root=200, rem=5; assert reset 50 cycles in.
  - All outputs go to 0 immediately and the state is IDLE.
  - After release, root=3, rem=2 gives value=11.
- Hold oper=1 after done; change root/rem while in DONE:
  - value is unchanged and no restart occurs.
  - Drop oper → done=0 on the next edge.
  - Re-raise oper → a new operation uses the new operands.

Source files
------------

// File: rtl/isqrt_recon.sv
// Purpose : rebuilds the 16-bit radicand root*root + rem by summing the first
//           `root` odd numbers onto rem, one addition per clock.
// Latency : done rises root+3 rising edges after the edge that samples oper=1 in IDLE.
// Backpressure: none; operands are captured once in LOAD, and later oper/root/rem
//           changes are ignored until the FSM is back in IDLE. done holds while oper=1.
// Ports   : clk, reset (async, active-high)
//           oper  - request level, sampled in IDLE
//           root  - 8-bit root operand, rem - 9-bit remainder operand
//           value - low 16 bits of root^2 + rem; ovf - sum >= 65536
//           bad_rem - rem > 2*root (non-canonical pair); done/busy - status
module isqrt_recon (
  input  logic        clk,
  input  logic        reset,
  input  logic        oper,
  input  logic [7:0]  root,
  input  logic [8:0]  rem,
  output logic [15:0] value,
  output logic        done,
  output logic        busy,
  output logic        ovf,
  output logic        bad_rem
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] ACC  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state;
  logic [7:0]  root_r;
  logic [8:0]  rem_r;
  logic [16:0] acc;   // 17 bits: peak is 65025 + 511 = 65536, so no wrap
  logic [8:0]  odd;   // next odd addend, reaches 511 after 255 additions
  logic [7:0]  cnt;

  assign done = (state == DONE);
  assign busy = (state == LOAD) || (state == ACC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      root_r  <= 8'd0;
      rem_r   <= 9'd0;
      acc     <= 17'd0;
      odd     <= 9'd0;
      cnt     <= 8'd0;
      value   <= 16'd0;
      ovf     <= 1'b0;
      bad_rem <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (oper) state <= LOAD;
        end
        LOAD: begin
          root_r  <= root;
          rem_r   <= rem;
          acc     <= {8'b0, rem};
          odd     <= 9'd1;
          cnt     <= 8'd0;
          value   <= 16'd0;
          ovf     <= 1'b0;
          bad_rem <= 1'b0;
          state   <= ACC;
        end
        ACC: begin
          if (cnt == root_r) begin
            // sum of first root_r odd numbers is root_r^2, so acc is final here
            state   <= DONE;
            value   <= acc[15:0];
            ovf     <= acc[16];
            bad_rem <= (rem_r > {root_r, 1'b0});
          end else begin
            acc <= acc + {8'b0, odd};
            odd <= odd + 9'd2;
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          // oper must drop before another request can be taken
          if (!oper) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_isqrt_recon.sv
module tb_isqrt_recon;

  logic        clk;
  logic        reset;
  logic        oper;
  logic [7:0]  root;
  logic [8:0]  rem;
  logic [15:0] value;
  logic        done;
  logic        busy;
  logic        ovf;
  logic        bad_rem;

  int total = 0;
  int bad   = 0;
  int viol  = 0;
  int n;

  isqrt_recon dut (
    .clk(clk), .reset(reset), .oper(oper), .root(root), .rem(rem),
    .value(value), .done(done), .busy(busy), .ovf(ovf), .bad_rem(bad_rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // busy and done must never be high together
  always @(negedge clk) if (busy && done) viol = viol + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Raise oper with operands, count edges until done (oper left high).
  task automatic run_op(input logic [7:0] r, input logic [8:0] m, output int edges);
    root = r;
    rem  = m;
    oper = 1'b1;
    edges = 0;
    while (1) begin
      @(posedge clk);
      #1;
      edges = edges + 1;
      if (edges == 2) begin
        chk("load_clears_value", {16'd0, value}, 32'd0);
        chk("busy_in_op", {31'd0, busy}, 32'd1);
      end
      if (done) break;
      if (edges >= 400) begin
        chk("done_timeout", 32'd0, 32'd1);
        break;
      end
    end
  endtask

  task automatic finish_op();
    oper = 1'b0;
    @(posedge clk);
    #1;
    chk("done_falls", {31'd0, done}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    oper  = 1'b0;
    root  = 8'd0;
    rem   = 9'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_value", {16'd0, value}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_bad_rem", {31'd0, bad_rem}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // root=31 rem=39 -> 961+39 = 1000
    run_op(8'd31, 9'd39, n);
    chk("t1_edges", n, 34);
    chk("t1_value", {16'd0, value}, 1000);
    chk("t1_ovf", {31'd0, ovf}, 0);
    chk("t1_bad_rem", {31'd0, bad_rem}, 0);
    chk("t1_busy_at_done", {31'd0, busy}, 0);
    finish_op();

    // root=10 rem=0 -> 100, then root=40 rem=9 -> 1609
    run_op(8'd10, 9'd0, n);
    chk("t2a_edges", n, 13);
    chk("t2a_value", {16'd0, value}, 100);
    finish_op();
    run_op(8'd40, 9'd9, n);
    chk("t2b_edges", n, 43);
    chk("t2b_value", {16'd0, value}, 1609);
    chk("t2b_bad_rem", {31'd0, bad_rem}, 0);
    finish_op();

    // root=0 rem=1 -> 1, non-canonical (1 > 0)
    run_op(8'd0, 9'd1, n);
    chk("t3_edges", n, 3);
    chk("t3_value", {16'd0, value}, 1);
    chk("t3_bad_rem", {31'd0, bad_rem}, 1);
    chk("t3_ovf", {31'd0, ovf}, 0);
    finish_op();

    // root=255 rem=510 -> 65535 ; rem=511 -> 65536 wraps to 0 with ovf
    run_op(8'd255, 9'd510, n);
    chk("t4a_edges", n, 258);
    chk("t4a_value", {16'd0, value}, 65535);
    chk("t4a_ovf", {31'd0, ovf}, 0);
    chk("t4a_bad_rem", {31'd0, bad_rem}, 0);
    finish_op();
    run_op(8'd255, 9'd511, n);
    chk("t4b_value", {16'd0, value}, 0);
    chk("t4b_ovf", {31'd0, ovf}, 1);
    chk("t4b_bad_rem", {31'd0, bad_rem}, 1);
    finish_op();

    // Leave a nonzero value behind so the reset clear is observable
    run_op(8'd2, 9'd1, n);
    chk("t5_pre_value", {16'd0, value}, 5);
    finish_op();

    // Reset mid-operation
    root = 8'd200;
    rem  = 9'd5;
    oper = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    chk("t5_busy_before_rst", {31'd0, busy}, 1);
    #2;
    reset = 1'b1;
    oper  = 1'b0;
    #1;
    chk("t5_rst_value", {16'd0, value}, 0);
    chk("t5_rst_busy", {31'd0, busy}, 0);
    chk("t5_rst_done", {31'd0, done}, 0);
    chk("t5_rst_ovf", {31'd0, ovf}, 0);
    chk("t5_rst_bad_rem", {31'd0, bad_rem}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_idle_no_busy", {31'd0, busy}, 0);
    run_op(8'd3, 9'd2, n);
    chk("t5_edges", n, 6);
    chk("t5_value", {16'd0, value}, 11);
    finish_op();

    // Hold oper in DONE and change operands: no restart, value stable
    run_op(8'd5, 9'd3, n);
    chk("t6_value", {16'd0, value}, 28);
    root = 8'd7;
    rem  = 9'd1;
    repeat (5) @(posedge clk);
    #1;
    chk("t6_hold_done", {31'd0, done}, 1);
    chk("t6_hold_busy", {31'd0, busy}, 0);
    chk("t6_hold_value", {16'd0, value}, 28);
    finish_op();
    run_op(8'd7, 9'd1, n);
    chk("t6_new_edges", n, 10);
    chk("t6_new_value", {16'd0, value}, 50);
    finish_op();

    chk("busy_done_exclusive", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
